// File: rtl/button_pulse_gen.sv
// button_pulse_gen: debounced push-button to single-cycle strobe; `BUTTON_AUTO_REPEAT_EN adds hold-to-repeat
module button_pulse_gen #(
  parameter int DB_CYCLES     = 16,
`ifdef BUTTON_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16,
`endif
  parameter int CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_button,
  output logic o_pulse,
  output logic o_level
);
  typedef enum logic [1:0] {IDLE = 2'b00, CHK_PRESS = 2'b01, HELD = 2'b10, CHK_RELEASE = 2'b11} state_t;
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DB_CYCLES - 1);
  state_t               state_q, state_d;
  logic                 s1_q, s_btn_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 level_q, level_d;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic [CNT_WIDTH-1:0] rcnt_q, rcnt_d;
  logic                 first_q, first_d;
`endif
  // debounce FSM: the only input it looks at is the synchronised button
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
`ifdef BUTTON_AUTO_REPEAT_EN
    rcnt_d  = rcnt_q;
    first_d = first_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef BUTTON_AUTO_REPEAT_EN
        rcnt_d = '0;
`endif
        if (s_btn_q) begin
          state_d = CHK_PRESS;
          cnt_d   = '0;
        end
      end
      CHK_PRESS: begin
        if (!s_btn_q) state_d = IDLE;
        else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
          level_d = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rcnt_d  = '0;
          first_d = 1'b1;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
      HELD: begin
        if (!s_btn_q) begin
          state_d = CHK_RELEASE;
          cnt_d   = '0;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (rcnt_q == CNT_WIDTH'(first_q ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
          pulse_d = 1'b1;
          rcnt_d  = '0;
          first_d = 1'b0;
        end else rcnt_d = rcnt_q + 1'b1;
`endif
      end
      CHK_RELEASE: begin
        if (s_btn_q) state_d = HELD;
        else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // synchroniser chain and FSM registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s_btn_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rcnt_q  <= '0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s1_q    <= i_button;
      s_btn_q <= s1_q;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
`endif
    end
  end
  assign o_pulse = pulse_q;
  assign o_level = level_q;
endmodule
